// File: rtl/quad_spinner_emu_pkg.sv
// Shared types and helpers for the quadrature spinner emulator.
// Latency: combinational helpers only.
// Backpressure: none; pure functions and constants.
package spinner_pkg;

    typedef logic [1:0] quad_t;

    localparam quad_t QUAD_IDLE = 2'b11;
    localparam int    DELTA_W   = 9;

    // One Gray-code step: dir=1 walks 11->01->00->10, dir=0 walks 11->10->00->01.
    function automatic quad_t quad_next(input quad_t q, input logic dir);
        quad_t n;
        if (dir) begin
            case (q)
                2'b11:   n = 2'b01;
                2'b01:   n = 2'b00;
                2'b00:   n = 2'b10;
                default: n = 2'b11;
            endcase
        end else begin
            case (q)
                2'b11:   n = 2'b10;
                2'b10:   n = 2'b00;
                2'b00:   n = 2'b01;
                default: n = 2'b11;
            endcase
        end
        return n;
    endfunction

    // a+b clamped to the symmetric range +-(2^(w-1)-1) of a w-bit backlog.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [32:0] sum;
        logic signed [32:0] lim;
        sum = $signed({a[31], a}) + $signed({b[31], b});
        lim = (33'sd1 <<< (w - 1)) - 33'sd1;
        if (sum > lim) begin
            sum = lim;
        end else if (sum < -lim) begin
            sum = -lim;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/quad_spinner_emu_if.sv
// Packed input/output bundle between the HPS input side and the spinner core.
// Latency: wires only.
// Backpressure: none; deltas are fire-and-forget pulses.
interface quad_spinner_emu_if #(
    parameter int CHANNELS = 1
);
    logic [CHANNELS-1:0]   delta_valid;
    logic [9*CHANNELS-1:0] delta;
    logic [CHANNELS-1:0]   joy_right;
    logic [CHANNELS-1:0]   joy_left;
    logic [CHANNELS-1:0]   joy_fast;
    logic [CHANNELS-1:0]   invert;
    logic [2*CHANNELS-1:0] quad;
    logic [CHANNELS-1:0]   busy;

    modport master (
        output delta_valid, delta, joy_right, joy_left, joy_fast, invert,
        input  quad, busy
    );

    modport slave (
        input  delta_valid, delta, joy_right, joy_left, joy_fast, invert,
        output quad, busy
    );
endinterface

// File: rtl/quad_spinner_emu_channel.sv
// One spinner channel: signed backlog, Gray-code output, joystick repeat.
// Latency: backlog/busy update 1 cycle after input; quad steps only on tick edges.
// Backpressure: none; new deltas merge into or replace the backlog.
module spinner_channel
    import spinner_pkg::*;
#(
    parameter int POS_W      = 12,
    parameter int JOY_PERIOD = 48000,
    parameter int JOY_SLOW   = 4,
    parameter int JOY_FAST   = 9
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      i_tick,
    input  logic                      i_delta_valid,
    input  logic signed [DELTA_W-1:0] i_delta,
    input  logic                      i_joy_right,
    input  logic                      i_joy_left,
    input  logic                      i_joy_fast,
    input  logic                      i_invert,
    output quad_t                     o_quad,
    output logic                      o_busy
);

    localparam int CNT_W = (JOY_PERIOD > 1) ? $clog2(JOY_PERIOD) : 1;

    logic signed [POS_W-1:0] r_backlog;
    quad_t                   r_quad;
    logic                    r_busy;
    logic [CNT_W-1:0]        r_joy_cnt;

    logic signed [31:0] w_cur;
    logic signed [31:0] w_dec;
    logic signed [31:0] w_dlt;
    logic signed [31:0] w_merged;
    logic signed [31:0] w_mag;
    logic signed [31:0] w_next;
    logic               w_step;
    logic               w_dir;
    logic               w_joy_one;
    logic               w_joy_load;
    logic [CNT_W-1:0]   w_cnt_next;

    // Next backlog: step toward zero, then merge the delta, then joystick reload wins.
    always_comb begin
        w_cur      = 32'(r_backlog);
        w_step     = i_tick && (r_backlog != '0);
        w_dir      = ~r_backlog[POS_W-1] ^ i_invert;
        w_dec      = w_cur;
        if (w_step) begin
            w_dec = r_backlog[POS_W-1] ? (w_cur + 32'sd1) : (w_cur - 32'sd1);
        end

        // Same-sign deltas accumulate; a reversal throws away stale motion.
        w_dlt    = 32'(i_delta);
        w_merged = w_dec;
        if (i_delta_valid && (i_delta != '0)) begin
            if ((w_dec != 32'sd0) && (w_dec[31] == w_dlt[31])) begin
                w_merged = sat_add(w_dec, w_dlt, POS_W);
            end else begin
                w_merged = sat_add(w_dlt, 32'sd0, POS_W);
            end
        end

        // Joystick repeat only runs while exactly one direction is held.
        w_joy_one  = i_joy_right ^ i_joy_left;
        w_joy_load = w_joy_one && (r_joy_cnt == CNT_W'(JOY_PERIOD - 1));
        w_cnt_next = '0;
        if (w_joy_one && !w_joy_load) begin
            w_cnt_next = r_joy_cnt + CNT_W'(1);
        end

        w_mag  = i_joy_fast ? JOY_FAST : JOY_SLOW;
        w_next = w_merged;
        if (w_joy_load) begin
            w_next = i_joy_right ? sat_add(w_mag, 32'sd0, POS_W)
                                 : sat_add(-w_mag, 32'sd0, POS_W);
        end
    end

    // Channel state; quad advances only when a step was taken this cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_backlog <= '0;
            r_quad    <= QUAD_IDLE;
            r_busy    <= 1'b0;
            r_joy_cnt <= '0;
        end else begin
            r_backlog <= w_next[POS_W-1:0];
            r_busy    <= (w_next != 32'sd0);
            r_joy_cnt <= w_cnt_next;
            if (w_step) begin
                r_quad <= quad_next(r_quad, w_dir);
            end
        end
    end

    assign o_quad = r_quad;
    assign o_busy = r_busy;

endmodule

// File: rtl/quad_spinner_emu.sv
// Multi-channel quadrature spinner emulator: shared step prescaler plus N channels.
// Latency: busy 1 cycle after a delta; first quad edge 1..STEP_DIV cycles later.
// Backpressure: none; each channel absorbs deltas into a saturating backlog.
module quad_spinner_emu
    import spinner_pkg::*;
#(
    parameter int CHANNELS   = 1,
    parameter int POS_W      = 12,
    parameter int STEP_DIV   = 64,
    parameter int JOY_PERIOD = 48000,
    parameter int JOY_SLOW   = 4,
    parameter int JOY_FAST   = 9
) (
    input  logic               clk_sys,
    input  logic               reset,
    quad_spinner_emu_if.slave  bus
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [DIV_W-1:0] r_presc;
    logic             w_tick;

    assign w_tick = (r_presc == DIV_W'(STEP_DIV - 1));

    // Free-running step prescaler; all channels step on the same wrap cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        spinner_channel #(
            .POS_W      (POS_W),
            .JOY_PERIOD (JOY_PERIOD),
            .JOY_SLOW   (JOY_SLOW),
            .JOY_FAST   (JOY_FAST)
        ) u_ch (
            .clk_sys       (clk_sys),
            .reset         (reset),
            .i_tick        (w_tick),
            .i_delta_valid (bus.delta_valid[i]),
            .i_delta       (bus.delta[DELTA_W*i +: DELTA_W]),
            .i_joy_right   (bus.joy_right[i]),
            .i_joy_left    (bus.joy_left[i]),
            .i_joy_fast    (bus.joy_fast[i]),
            .i_invert      (bus.invert[i]),
            .o_quad        (bus.quad[2*i +: 2]),
            .o_busy        (bus.busy[i])
        );
    end

endmodule

// File: tb/tb_quad_spinner_emu.sv
// Directed bench for quad_spinner_emu with two channels and a fast prescaler.
// Latency: observes outputs 1 time unit after every rising edge.
// Backpressure: none.
module tb_quad_spinner_emu;

    localparam int CH         = 2;
    localparam int POS_W      = 8;
    localparam int STEP_DIV   = 4;
    localparam int JOY_PERIOD = 10;
    localparam int JOY_SLOW   = 4;
    localparam int JOY_FAST   = 9;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    quad_spinner_emu_if #(.CHANNELS(CH)) bus ();

    quad_spinner_emu #(
        .CHANNELS   (CH),
        .POS_W      (POS_W),
        .STEP_DIV   (STEP_DIV),
        .JOY_PERIOD (JOY_PERIOD),
        .JOY_SLOW   (JOY_SLOW),
        .JOY_FAST   (JOY_FAST)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_double = 0;

    logic [1:0] prev_q [CH];
    int         steps  [CH];
    logic [1:0] hist0 [$];
    logic [1:0] hist1 [$];
    logic       busy_at0 [$];
    int         cyc_at0 [$];
    int         cyc_at1 [$];

    // Advance one clock and log every quad change per channel.
    task automatic tick_cycle();
        @(posedge clk_sys);
        #1;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            logic [1:0] q;
            q = bus.quad[2*c +: 2];
            if (!reset && (q !== prev_q[c])) begin
                if ((q ^ prev_q[c]) == 2'b11) n_double++;
                steps[c]++;
                if (c == 0) begin
                    hist0.push_back(q);
                    busy_at0.push_back(bus.busy[0]);
                    cyc_at0.push_back(cyc);
                end else begin
                    hist1.push_back(q);
                    cyc_at1.push_back(cyc);
                end
            end
            prev_q[c] = q;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic wait_hist0(input int target, input int budget);
        int n;
        n = 0;
        while ((hist0.size() < target) && (n < budget)) begin
            tick_cycle();
            n++;
        end
    endtask

    task automatic pulse0(input logic [8:0] d);
        bus.delta       = '0;
        bus.delta[8:0]  = d;
        bus.delta_valid = 2'b01;
        tick_cycle();
        bus.delta_valid = '0;
        bus.delta       = '0;
    endtask

    task automatic do_reset();
        bus.delta_valid = '0;
        bus.delta       = '0;
        bus.joy_right   = '0;
        bus.joy_left    = '0;
        bus.joy_fast    = '0;
        bus.invert      = '0;
        reset = 1'b1;
        tick_cycle();
        tick_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int s0, s1;
        do_reset();
        checks++; if (bus.quad !== 4'b1111) begin errors++; $display("FAIL reset_quad got %b want 1111", bus.quad); end
        checks++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", bus.busy); end
        s0 = steps[0]; s1 = steps[1];
        run(1000);
        checks++; if ((steps[0] - s0) + (steps[1] - s1) !== 0) begin errors++; $display("FAIL idle_steps got %0d want 0", (steps[0] - s0) + (steps[1] - s1)); end
        checks++; if (bus.quad !== 4'b1111) begin errors++; $display("FAIL idle_quad got %b want 1111", bus.quad); end
        checks++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL idle_busy got %b want 00", bus.busy); end
    endtask

    task automatic test_single_step();
        int s0, s1, c0, lat;
        s0 = hist0.size(); s1 = steps[1];
        pulse0(9'd3);
        c0 = cyc;
        checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b want 1", bus.busy[0]); end
        wait_hist0(s0 + 3, 40);
        run(12);
        checks++; if (hist0.size() - s0 !== 3) begin errors++; $display("FAIL single_count got %0d want 3", hist0.size() - s0); end
        checks++; if ({hist0[s0], hist0[s0+1], hist0[s0+2]} !== 6'b01_00_10) begin
            errors++; $display("FAIL single_seq got %b want 010010", {hist0[s0], hist0[s0+1], hist0[s0+2]}); end
        lat = cyc_at0[s0] - c0;
        checks++; if (lat < 1 || lat > STEP_DIV) begin errors++; $display("FAIL single_latency got %0d want 1..%0d", lat, STEP_DIV); end
        checks++; if (cyc_at0[s0+1] - cyc_at0[s0] !== STEP_DIV) begin errors++; $display("FAIL single_rate got %0d want %0d", cyc_at0[s0+1] - cyc_at0[s0], STEP_DIV); end
        checks++; if ({busy_at0[s0+1], busy_at0[s0+2]} !== 2'b10) begin errors++; $display("FAIL single_busy_fall got %b want 10", {busy_at0[s0+1], busy_at0[s0+2]}); end
        checks++; if ((steps[1] - s1 !== 0) || (bus.quad[3:2] !== 2'b11)) begin
            errors++; $display("FAIL single_ch1_idle got steps %0d quad %b want 0 11", steps[1] - s1, bus.quad[3:2]); end
        checks++; if (n_double !== 0) begin errors++; $display("FAIL gray_single got %0d double changes want 0", n_double); end
    endtask

    task automatic test_reversal();
        int s0, r;
        do_reset();
        s0 = hist0.size();
        pulse0(9'd5);
        wait_hist0(s0 + 2, 20);
        pulse0(9'h1FE);
        r = hist0.size();
        checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL rev_busy got %b want 1", bus.busy[0]); end
        wait_hist0(r + 2, 20);
        run(16);
        checks++; if (hist0.size() - r !== 2) begin errors++; $display("FAIL rev_count got %0d want 2", hist0.size() - r); end
        checks++; if ({hist0[s0], hist0[s0+1], hist0[s0+2], hist0[s0+3]} !== 8'b01_00_01_11) begin
            errors++; $display("FAIL rev_seq got %b want 01000111", {hist0[s0], hist0[s0+1], hist0[s0+2], hist0[s0+3]}); end
        checks++; if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL rev_busy_end got %b want 0", bus.busy[0]); end
    endtask

    task automatic test_delta_zero();
        int s0;
        s0 = hist0.size();
        pulse0(9'd0);
        checks++; if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL zero_idle_busy got %b want 0", bus.busy[0]); end
        pulse0(9'd3);
        pulse0(9'd0);
        wait_hist0(s0 + 3, 40);
        run(16);
        checks++; if (hist0.size() - s0 !== 3) begin errors++; $display("FAIL zero_keep_count got %0d want 3", hist0.size() - s0); end
    endtask

    task automatic test_invert();
        int s0;
        do_reset();
        bus.invert = 2'b01;
        s0 = hist0.size();
        pulse0(9'd2);
        wait_hist0(s0 + 2, 20);
        run(12);
        checks++; if (hist0.size() - s0 !== 2) begin errors++; $display("FAIL inv_count got %0d want 2", hist0.size() - s0); end
        checks++; if ({hist0[s0], hist0[s0+1]} !== 4'b10_00) begin errors++; $display("FAIL inv_seq got %b want 1000", {hist0[s0], hist0[s0+1]}); end
        bus.invert = '0;
    endtask

    task automatic test_two_channel();
        int s0, s1;
        do_reset();
        s0 = hist0.size(); s1 = hist1.size();
        bus.delta       = {9'h1FF, 9'd2};
        bus.delta_valid = 2'b11;
        tick_cycle();
        bus.delta_valid = '0;
        bus.delta       = '0;
        checks++; if (bus.busy !== 2'b11) begin errors++; $display("FAIL two_busy got %b want 11", bus.busy); end
        wait_hist0(s0 + 2, 20);
        run(12);
        checks++; if ({hist0[s0], hist0[s0+1]} !== 4'b01_00) begin errors++; $display("FAIL two_ch0_seq got %b want 0100", {hist0[s0], hist0[s0+1]}); end
        checks++; if ((hist1.size() - s1 !== 1) || (hist1[s1] !== 2'b10)) begin
            errors++; $display("FAIL two_ch1 got %0d steps quad %b want 1 10", hist1.size() - s1, hist1[s1]); end
        checks++; if (cyc_at1[s1] !== cyc_at0[s0]) begin errors++; $display("FAIL two_same_tick got %0d want %0d", cyc_at1[s1], cyc_at0[s0]); end
        checks++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL two_busy_end got %b want 00", bus.busy); end
    endtask

    task automatic test_saturation();
        int         s0, bad;
        logic [1:0] fwd [4];
        fwd[0] = 2'b01; fwd[1] = 2'b00; fwd[2] = 2'b10; fwd[3] = 2'b11;
        do_reset();
        run(3);
        s0 = hist0.size();
        bus.delta[8:0]  = 9'd100;
        bus.delta_valid = 2'b01;
        run(4);
        bus.delta_valid = '0;
        bus.delta       = '0;
        checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL sat_busy got %b want 1", bus.busy[0]); end
        wait_hist0(s0 + 127, 127 * STEP_DIV + 40);
        run(20);
        checks++; if (hist0.size() - s0 !== 127) begin errors++; $display("FAIL sat_count got %0d want 127", hist0.size() - s0); end
        bad = 0;
        for (int k = 0; k < 127; k++) if (hist0[s0+k] !== fwd[k % 4]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL sat_direction got %0d wrong steps want 0", bad); end
        checks++; if ({busy_at0[s0+125], busy_at0[s0+126]} !== 2'b10) begin
            errors++; $display("FAIL sat_busy_fall got %b want 10", {busy_at0[s0+125], busy_at0[s0+126]}); end
        checks++; if (bus.quad[1:0] !== 2'b10) begin errors++; $display("FAIL sat_final_quad got %b want 10", bus.quad[1:0]); end
    endtask

    task automatic test_joystick();
        int s0;
        do_reset();
        s0 = hist0.size();
        bus.joy_fast  = 2'b01;
        bus.joy_right = 2'b01;
        run(JOY_PERIOD - 1);
        bus.joy_right = '0;
        run(20);
        checks++; if ((hist0.size() - s0 !== 0) || (bus.busy[0] !== 1'b0)) begin
            errors++; $display("FAIL joy_short got %0d steps busy %b want 0 0", hist0.size() - s0, bus.busy[0]); end
        bus.joy_right = 2'b01;
        run(JOY_PERIOD);
        bus.joy_right = '0;
        checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL joy_load_busy got %b want 1", bus.busy[0]); end
        wait_hist0(s0 + 9, 60);
        run(16);
        checks++; if (hist0.size() - s0 !== 9) begin errors++; $display("FAIL joy_fast_count got %0d want 9", hist0.size() - s0); end
        checks++; if (bus.quad[1:0] !== 2'b01) begin errors++; $display("FAIL joy_fast_quad got %b want 01", bus.quad[1:0]); end
        s0 = hist0.size();
        bus.joy_left  = 2'b01;
        bus.joy_right = 2'b01;
        run(40);
        bus.joy_left  = '0;
        bus.joy_right = '0;
        run(8);
        checks++; if ((hist0.size() - s0 !== 0) || (bus.busy[0] !== 1'b0)) begin
            errors++; $display("FAIL joy_both got %0d steps busy %b want 0 0", hist0.size() - s0, bus.busy[0]); end
        bus.joy_fast = '0;
        bus.joy_left = 2'b01;
        run(JOY_PERIOD);
        bus.joy_left = '0;
        wait_hist0(s0 + 4, 40);
        run(16);
        checks++; if (hist0.size() - s0 !== 4) begin errors++; $display("FAIL joy_slow_count got %0d want 4", hist0.size() - s0); end
        checks++; if ({hist0[s0], hist0[s0+1], hist0[s0+2], hist0[s0+3]} !== 8'b11_10_00_01) begin
            errors++; $display("FAIL joy_slow_seq got %b want 11100001", {hist0[s0], hist0[s0+1], hist0[s0+2], hist0[s0+3]}); end
    endtask

    task automatic test_reset_mid();
        int s0;
        do_reset();
        s0 = hist0.size();
        pulse0(9'd50);
        run(10);
        checks++; if (hist0.size() - s0 < 1) begin errors++; $display("FAIL mid_running got %0d steps want >=1", hist0.size() - s0); end
        reset = 1'b1;
        tick_cycle();
        reset = 1'b0;
        checks++; if ({bus.quad, bus.busy} !== 6'b1111_00) begin errors++; $display("FAIL mid_reset got %b want 111100", {bus.quad, bus.busy}); end
        s0 = hist0.size();
        run(40);
        checks++; if (hist0.size() - s0 !== 0) begin errors++; $display("FAIL mid_after got %0d steps want 0", hist0.size() - s0); end
        checks++; if (n_double !== 0) begin errors++; $display("FAIL gray_total got %0d double changes want 0", n_double); end
    endtask

    initial begin
        bus.delta_valid = '0;
        bus.delta       = '0;
        bus.joy_right   = '0;
        bus.joy_left    = '0;
        bus.joy_fast    = '0;
        bus.invert      = '0;
        for (int c = 0; c < CH; c++) begin
            prev_q[c] = 2'b11;
            steps[c]  = 0;
        end
        test_reset();
        test_single_step();
        test_reversal();
        test_delta_zero();
        test_invert();
        test_two_channel();
        test_saturation();
        test_joystick();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_spinner_emu.md
# quad_spinner_emu

Multi-channel emulator for quadrature (A/B) spinner encoders, driven by relative mouse deltas and digital joystick directions. It sits between the HPS input bus (mouse packets, joystick bits) and arcade cores that sample spinner pins, such as paddle games. Each channel keeps a signed motion backlog and drains it as Gray-code encoder steps at a programmable rate. It generalises our single-channel spinner logic to N channels, with direction invert, saturation and a parametrised joystick repeat.

## Interface
- CHANNELS, 1: number of independent spinner channels
- POS_W, 12: width of the signed per-channel backlog accumulator
- STEP_DIV, 64: clk_sys cycles per encoder step tick (≥2)
- JOY_PERIOD, 48000: clk_sys cycles between joystick backlog reloads
- JOY_SLOW, 4: backlog magnitude loaded per joystick reload
- JOY_FAST, 9: magnitude loaded when fast is held

Ports:
- clk_sys  in  1  system clock
- reset  in  1  reset; synchronous and active-high
- delta_valid  in  CHANNELS  one-cycle pulse: new mouse delta for channel i
- delta  in  9*CHANNELS  signed 9-bit delta per channel (bits 9i+8:9i)
- joy_right  in  CHANNELS  digital right/clockwise, active-high
- joy_left  in  CHANNELS  digital left, active-high
- joy_fast  in  CHANNELS  selects JOY_FAST magnitude
- invert  in  CHANNELS  reverses step direction (static setting)
- quad  out  2*CHANNELS  encoder {A,B} per channel (bits 2i+1:2i)
- busy  out  CHANNELS  backlog for channel i is non-zero

## Operation
- Reset state: quad = 2'b11 on every channel; backlog = 0; busy = 0; prescaler = 0; joystick counters = 0.
- Prescaler:
  - Shared counter runs 0..STEP_DIV-1.
  - `tick` is asserted for one cycle at the wrap.
- Step, on tick with backlog ≠ 0:
  - Direction is d = sign(backlog) XOR invert.
  - Positive d advances quad 11→01→00→10→11.
  - Negative d advances quad 11→10→00→01→11.
  - The backlog moves one unit toward 0.
- Delta merge:
  - The 9-bit delta is sign-extended to POS_W.
  - Same sign as the backlog: add, saturating at ±(2^(POS_W-1)−1).
  - Backlog 0 or opposite sign: the backlog is replaced by delta. A direction reversal discards stale motion.
  - Delta value 0 leaves the backlog unchanged.
- Joystick, per channel:
  - Exactly one of left/right held: the counter increments.
  - On reaching JOY_PERIOD−1, the backlog loads +mag (right) or −mag (left), and the counter returns to 0. mag is JOY_FAST if joy_fast, else JOY_SLOW.
  - Neither held, or both held: the counter is forced to 0 and no load occurs.
- Same-cycle priority, evaluated in order:
  1. Step decrement.
  2. Delta merge applied to the decremented value.
  3. Joystick load overrides both.
  The quad step still occurs if the pre-update backlog was non-zero.
- busy = (backlog ≠ 0), registered.

## Timing
- quad changes only on the clk_sys edge ending a tick cycle, by at most one state per tick. A and B never change together.
- delta_valid to first quad change: 1..STEP_DIV cycles. Tick phase is not reset by deltas.
- busy rises 1 cycle after a delta_valid that makes the backlog non-zero.
- busy falls on the edge of the step that empties the backlog.
- Reset asserted mid-operation: all state returns to reset values on the next edge. quad may jump directly to 11; this is allowed.
- Saturation: a backlog at +max plus a positive delta stays at +max; no wrap.
- Steady-state output rate: one step per STEP_DIV cycles per channel; all channels step on the same tick.

## Structure
- Package `spinner_pkg`:
  - typedef `quad_t` (logic [1:0]);
  - constant `QUAD_IDLE` = 2'b11;
  - function `quad_next(quad_t q, logic dir)` implementing both Gray sequences;
  - function `sat_add` parametrised by width.
- Sub-module `spinner_channel`:
  - holds the backlog, quad register, joystick counter and merge logic;
  - instantiated CHANNELS times by generate.
- The top level holds the shared prescaler and the bit-slicing of packed ports.

## Test plan
- Reset, then idle 1000 cycles → quad=11 and busy=0 on all channels; no transitions.
- CHANNELS=2, STEP_DIV=4: delta=+3 on ch0 → ch0 quad 11→01→00→10 on three successive ticks; busy clears on the third; ch1 stays 11.
- ch0 delta=+5, then delta=−2 before the backlog drains → backlog replaced by −2; next steps follow 11-direction reverse order; exactly 2 steps after the reversal.
- invert[0]=1 with delta=+2 → sequence 11→10→00, the negative order.
- POS_W=8: four deltas of +100 → backlog saturates at 127; exactly 127 steps then busy=0.
- JOY_PERIOD=10, joy_right held 10 cycles with joy_fast=1 → backlog loads +9 and 9 forward steps follow. Both left and right held → no load, quad static.
